// File: rtl/cache_line_fill_array.sv
// N-way cache data array with byte-enabled CPU word access and a beat-based line-fill sequencer.
// Optional early restart (critical-word forwarding during refill) enabled by defining CACHE_FILL_FWD_EN.
module cache_line_fill_array #(
    parameter int NUM_WAYS       = 4,
    parameter int INDEX_WIDTH    = 6,
    parameter int WORDS_PER_LINE = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int BEAT_WORDS     = 4,
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int OFF_W = $clog2(WORDS_PER_LINE),
    localparam int BE_W  = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cpu_req_valid,
    output logic                             cpu_req_ready,
    input  logic                             cpu_we,
    input  logic [BE_W-1:0]                  cpu_be,
    input  logic [INDEX_WIDTH-1:0]           cpu_index,
    input  logic [WAY_W-1:0]                 cpu_way,
    input  logic [OFF_W-1:0]                 cpu_offset,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    output logic                             rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    input  logic                             fill_start,
    input  logic [INDEX_WIDTH-1:0]           fill_index,
    input  logic [WAY_W-1:0]                 fill_way,
    input  logic [OFF_W-1:0]                 fill_word,
    input  logic                             mem_valid,
    output logic                             mem_ready,
    input  logic [BEAT_WORDS*DATA_WIDTH-1:0] mem_data,
    output logic                             fill_busy,
    output logic                             fill_done
);

    localparam int BEATS  = WORDS_PER_LINE / BEAT_WORDS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_W = WAY_W + INDEX_WIDTH + OFF_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [BEAT_W-1:0]        beat_cnt;
    logic [INDEX_WIDTH-1:0]   fill_index_q;
    logic [WAY_W-1:0]         fill_way_q;
    logic [DATA_WIDTH-1:0]    store [DEPTH];

    logic                     cpu_rd;
    logic                     cpu_wr;
    logic                     beat_acc;
    logic                     last_beat;
    logic [ADDR_W-1:0]        cpu_addr;
    logic [OFF_W-1:0]         fill_base;
    logic                     fwd_hit;
    logic [DATA_WIDTH-1:0]    fwd_word;

    assign cpu_rd    = cpu_req_valid && cpu_req_ready && !cpu_we;
    assign cpu_wr    = cpu_req_valid && cpu_req_ready && cpu_we;
    assign beat_acc  = mem_valid && mem_ready;
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    assign cpu_addr  = {cpu_way, cpu_index, cpu_offset};
    assign fill_base = OFF_W'(32'(beat_cnt) * 32'(BEAT_WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // cpu_req_ready is also gated by reset so every output reads 0 while reset is held.
    always_comb begin
        next_state    = state;
        cpu_req_ready = 1'b0;
        mem_ready     = 1'b0;
        fill_busy     = 1'b0;
        fill_done     = 1'b0;
        case (state)
            IDLE: begin
                cpu_req_ready = reset && !fill_start;
                if (fill_start) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                mem_ready = 1'b1;
                fill_busy = 1'b1;
                if (mem_valid && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                fill_busy  = 1'b1;
                fill_done  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef CACHE_FILL_FWD_EN
    logic [OFF_W-1:0] fill_word_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_word_q <= '0;
        end else if (state == IDLE && fill_start) begin
            fill_word_q <= fill_word;
        end
    end

    assign fwd_hit = beat_acc && ((32'(fill_word_q) / 32'(BEAT_WORDS)) == 32'(beat_cnt));

    always_comb begin
        fwd_word = '0;
        for (int unsigned k = 0; k < BEAT_WORDS; k++) begin
            if (k == (32'(fill_word_q) % 32'(BEAT_WORDS))) begin
                fwd_word = mem_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
`else
    logic [OFF_W-1:0] unused_fill_word;

    assign unused_fill_word = fill_word;
    assign fwd_hit          = 1'b0;
    assign fwd_word         = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt     <= '0;
            fill_index_q <= '0;
            fill_way_q   <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (state == IDLE && fill_start) begin
                fill_index_q <= fill_index;
                fill_way_q   <= fill_way;
            end
            if (beat_acc) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            // CPU reads only happen in IDLE and forwarding only in FILL, so the two never collide.
            rd_valid <= cpu_rd || fwd_hit;
            if (cpu_rd) begin
                rd_data <= store[cpu_addr];
            end else if (fwd_hit) begin
                rd_data <= fwd_word;
            end
        end
    end

    // Storage is never reset; contents survive a reset asserted mid-fill.
    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (cpu_be[b]) begin
                    store[cpu_addr][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
                end
            end
        end
        if (beat_acc) begin
            for (int unsigned k = 0; k < BEAT_WORDS; k++) begin
                store[{fill_way_q, fill_index_q, fill_base + OFF_W'(k)}] <=
                    mem_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_cache_line_fill_array.sv
// Self-checking bench for cache_line_fill_array: vector table for CPU access, hand sequences for fills.
// Read results (CPU and, with CACHE_FILL_FWD_EN, forwarded words) are checked through a scoreboard queue.
module tb_cache_line_fill_array;

    localparam int NW    = 4;
    localparam int IW    = 6;
    localparam int WPL   = 16;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int BEATS = WPL / BW;

    logic          clk;
    logic          reset;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_we;
    logic [3:0]    cpu_be;
    logic [5:0]    cpu_index;
    logic [1:0]    cpu_way;
    logic [3:0]    cpu_offset;
    logic [31:0]   cpu_wdata;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          fill_start;
    logic [5:0]    fill_index;
    logic [1:0]    fill_way;
    logic [3:0]    fill_word;
    logic          mem_valid;
    logic          mem_ready;
    logic [127:0]  mem_data;
    logic          fill_busy;
    logic          fill_done;

    cache_line_fill_array #(
        .NUM_WAYS      (NW),
        .INDEX_WIDTH   (IW),
        .WORDS_PER_LINE(WPL),
        .DATA_WIDTH    (DW),
        .BEAT_WORDS    (BW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .cpu_we       (cpu_we),
        .cpu_be       (cpu_be),
        .cpu_index    (cpu_index),
        .cpu_way      (cpu_way),
        .cpu_offset   (cpu_offset),
        .cpu_wdata    (cpu_wdata),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .fill_start   (fill_start),
        .fill_index   (fill_index),
        .fill_way     (fill_way),
        .fill_word    (fill_word),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done)
    );

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [1:0]  way;
        logic [5:0]  idx;
        logic [3:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[16];
    int          checks;
    int          errors;
    int unsigned cyc;
    int          done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no response within budget, expected response", name);
    endtask

    // Every rd_valid pulse must match the oldest expected read, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (fill_done) done_cnt++;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 rd_data=%h, expected no pulse", rd_data);
            end else begin
                e = sb.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_latency", cyc, e.due);
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [3:0] be, input logic [1:0] way,
                          input logic [5:0] idx, input logic [3:0] off,
                          input logic [31:0] wdata, input logic [31:0] exp, output int waited);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_be        = be;
        cpu_way       = way;
        cpu_index     = idx;
        cpu_offset    = off;
        cpu_wdata     = wdata;
        #1;
        waited = 0;
        while (!cpu_req_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!cpu_req_ready) begin
            timeout_fail("cpu_accept");
        end else if (!we) begin
            sb.push_back('{exp, cyc + 1});
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_we        = 1'b0;
    endtask

    task automatic drive_beat(input int b, input logic [31:0] base);
        for (int k = 0; k < BW; k++) begin
            mem_data[k*DW +: DW] = base + 32'(b * BW + k);
        end
        mem_valid = 1'b1;
    endtask

    task automatic do_fill(input logic [1:0] way, input logic [5:0] idx, input logic [3:0] word,
                           input logic [31:0] base, input int gap, input bit dup_start);
        @(negedge clk);
        fill_start = 1'b1;
        fill_way   = way;
        fill_index = idx;
        fill_word  = word;
        #1;
        check("req_ready_at_fill_start", 32'(cpu_req_ready), 32'd0);
        @(negedge clk);
        fill_start = 1'b0;
        fill_way   = way ^ 2'd1;
        fill_index = idx ^ 6'd1;
        fill_word  = word ^ 4'd1;
        #1;
        check("busy_in_fill", 32'(fill_busy), 32'd1);
        for (int b = 0; b < BEATS; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                #1;
                check("req_ready_in_stall", 32'(cpu_req_ready), 32'd0);
                check("mem_ready_in_stall", 32'(mem_ready), 32'd1);
            end
            drive_beat(b, base);
            if (dup_start && b == 1) begin
                fill_start = 1'b1;
                fill_index = 6'd7;
            end
            #1;
            check("mem_ready_at_beat", 32'(mem_ready), 32'd1);
            check("req_ready_at_beat", 32'(cpu_req_ready), 32'd0);
            check("done_early", 32'(fill_done), 32'd0);
`ifdef CACHE_FILL_FWD_EN
            if (b == int'(word) / BW) sb.push_back('{base + 32'(word), cyc + 1});
`endif
            @(negedge clk);
            mem_valid  = 1'b0;
            fill_start = 1'b0;
            #1;
        end
        check("fill_done_pulse", 32'(fill_done), 32'd1);
        check("busy_in_done", 32'(fill_busy), 32'd1);
        check("mem_ready_in_done", 32'(mem_ready), 32'd0);
        check("req_ready_in_done", 32'(cpu_req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("fill_done_clear", 32'(fill_done), 32'd0);
        check("busy_clear", 32'(fill_busy), 32'd0);
        check("req_ready_after_fill", 32'(cpu_req_ready), 32'd1);
    endtask

    task automatic read_line(input logic [1:0] way, input logic [5:0] idx, input logic [31:0] base);
        int w;
        for (int o = 0; o < WPL; o++) begin
            cpu_op(1'b0, 4'h0, way, idx, 4'(o), 32'h0, base + 32'(o), w);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(cpu_req_ready), 32'd0);
        check({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
        check({tag, "_fill_busy"}, 32'(fill_busy), 32'd0);
        check({tag, "_fill_done"}, 32'(fill_done), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'h0);
    endtask

    initial begin
        int waited;
        int d0;
        checks = 0;
        errors = 0;
        cyc = 0;
        done_cnt = 0;
        reset = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_we = 1'b0;
        cpu_be = 4'h0;
        cpu_index = '0;
        cpu_way = '0;
        cpu_offset = '0;
        cpu_wdata = '0;
        fill_start = 1'b0;
        fill_index = '0;
        fill_way = '0;
        fill_word = '0;
        mem_valid = 1'b0;
        mem_data = '0;

        vecs[0]  = '{1'b1, 4'hF, 2'd2, 6'd5,  4'd3,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 2'd2, 6'd5,  4'd3,  32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'hF, 2'd1, 6'd5,  4'd3,  32'h55555555, 32'h0};
        vecs[3]  = '{1'b0, 4'h0, 2'd2, 6'd5,  4'd3,  32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b0, 4'h0, 2'd1, 6'd5,  4'd3,  32'h0,        32'h55555555};
        vecs[5]  = '{1'b1, 4'hF, 2'd0, 6'd0,  4'd0,  32'h11223344, 32'h0};
        vecs[6]  = '{1'b1, 4'h2, 2'd0, 6'd0,  4'd0,  32'h0000AA00, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 2'd0, 6'd0,  4'd0,  32'h0,        32'h1122AA44};
        vecs[8]  = '{1'b1, 4'hF, 2'd3, 6'd63, 4'd15, 32'h00000000, 32'h0};
        vecs[9]  = '{1'b1, 4'h9, 2'd3, 6'd63, 4'd15, 32'hAABBCCDD, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 2'd3, 6'd63, 4'd15, 32'h0,        32'hAA0000DD};
        vecs[11] = '{1'b1, 4'hF, 2'd2, 6'd5,  4'd4,  32'h12345678, 32'h0};
        vecs[12] = '{1'b1, 4'h0, 2'd2, 6'd5,  4'd4,  32'hFFFFFFFF, 32'h0};
        vecs[13] = '{1'b0, 4'h0, 2'd2, 6'd5,  4'd4,  32'h0,        32'h12345678};
        vecs[14] = '{1'b1, 4'hC, 2'd2, 6'd5,  4'd3,  32'hCAFE0000, 32'h0};
        vecs[15] = '{1'b0, 4'h0, 2'd2, 6'd5,  4'd3,  32'h0,        32'hCAFEBEEF};

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        #1;
        check("req_ready_after_reset", 32'(cpu_req_ready), 32'd1);

        // CPU writes, byte-enabled writes, and read-back
        for (int i = 0; i < 16; i++) begin
            cpu_op(vecs[i].we, vecs[i].be, vecs[i].way, vecs[i].idx, vecs[i].off,
                   vecs[i].wdata, vecs[i].exp, waited);
        end

        // Gapped fill of way1/set9, critical word 9
        d0 = done_cnt;
        do_fill(2'd1, 6'd9, 4'd9, 32'h100, 2, 1'b0);
        check("single_done_fill1", 32'(done_cnt - d0), 32'd1);
        read_line(2'd1, 6'd9, 32'h100);

        // CPU request coincident with fill_start, plus a second fill_start mid-fill
        d0 = done_cnt;
        fork
            do_fill(2'd3, 6'd9, 4'd2, 32'h200, 1, 1'b1);
            cpu_op(1'b0, 4'h0, 2'd1, 6'd9, 4'd5, 32'h0, 32'h105, waited);
        join
        check("cpu_stalled_by_fill", 32'(waited >= BEATS * 2 + 2), 32'd1);
        check("single_done_fill2", 32'(done_cnt - d0), 32'd1);
        read_line(2'd3, 6'd9, 32'h200);

        // Reset asserted while beat 2 of a fill is on the bus
        d0 = done_cnt;
        @(negedge clk);
        fill_start = 1'b1;
        fill_way   = 2'd0;
        fill_index = 6'd20;
        fill_word  = 4'd12;
        @(negedge clk);
        fill_start = 1'b0;
        drive_beat(0, 32'h3A0);
        @(negedge clk);
        drive_beat(1, 32'h3A0);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("mid_fill_reset");
        @(negedge clk);
        #1;
        check_all_zero("mid_fill_reset_held");
        mem_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("req_ready_after_abort", 32'(cpu_req_ready), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("busy_after_abort", 32'(fill_busy), 32'd0);
        check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
        do_fill(2'd0, 6'd20, 4'd12, 32'h300, 0, 1'b0);
        check("single_done_refill", 32'(done_cnt - d0), 32'd1);
        read_line(2'd0, 6'd20, 32'h300);

        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
